// File: rtl/fifo_wr_arb_pkg.sv
// fifo_arb_pkg: shared types, default sizes and the round-robin pointer wrap
// helper for the fifo_wr_arb write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int N_REQ_DEF = 4;
  localparam int DW_DEF    = 8;
  localparam int LEN_W_DEF = 4;

  // Next pointer after ptr, wrapping n-1 back to 0 (also for non-power-of-two n).
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// fifo_wr_arb_if: requester bundle plus FIFO write port seen by fifo_wr_arb.
// master = requesters / FIFO side, slave = the arbiter itself.
interface fifo_wr_arb_if
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW    = DW_DEF,
  parameter int LEN_W = LEN_W_DEF
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*LEN_W-1:0] req_len;
  logic [N_REQ*DW-1:0]    req_data;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       data_ack;
  logic                   w_en;
  logic [DW-1:0]          w_data;
  logic                   w_full;
  logic                   busy;
  logic [ID_W-1:0]        cur_id;

  modport master (
    output req, req_len, req_data, w_full,
    input  gnt, data_ack, w_en, w_data, busy, cur_id
  );

  modport slave (
    input  req, req_len, req_data, w_full,
    output gnt, data_ack, w_en, w_data, busy, cur_id
  );

endinterface

// File: rtl/fifo_wr_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Scans from ptr_i upwards with
// wrap and returns the first requester found as one-hot and as an index.
// Option macro FIFO_WR_ARB_PRIO0_EN: requester 0 wins outright whenever it
// requests; the rest share the round-robin scan.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_oh_o,
  output logic [$clog2(N_REQ)-1:0] gnt_idx_o,
  output logic                     any_o
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req_rr;
  logic [ID_W:0]    idx;

`ifdef FIFO_WR_ARB_PRIO0_EN
  // Requester 0 is handled by the override below, keep it out of the scan.
  assign req_rr = req_i & ~N_REQ'(1);
`else
  assign req_rr = req_i;
`endif

  // Round-robin scan starting at the pointer; the first hit wins.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr_i} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
      if (!any_o && req_rr[idx[ID_W-1:0]]) begin
        any_o                     = 1'b1;
        gnt_oh_o[idx[ID_W-1:0]]   = 1'b1;
        gnt_idx_o                 = idx[ID_W-1:0];
      end
    end
`ifdef FIFO_WR_ARB_PRIO0_EN
    if (req_i[0]) begin
      gnt_oh_o  = N_REQ'(1);
      gnt_idx_o = '0;
      any_o     = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: shares the FIFO write port among N_REQ burst producers.
// IDLE picks a winner, BURST streams len+1 beats honouring w_full.
// Option macro FIFO_WR_ARB_PRIO0_EN: strict priority for requester 0, and
// the round-robin pointer never lands on index 0.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW    = DW_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic          w_clk,
  input  logic          rst,
  fifo_wr_arb_if.slave  bus
);
  localparam int ID_W = $clog2(N_REQ);

  arb_state_e       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  cur_id_q, cur_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;

  logic [N_REQ-1:0] win_oh;
  logic [ID_W-1:0]  win_idx;
  logic             win_any;
  logic [ID_W-1:0]  next_ptr;
  logic             in_burst;
  logic             wr_fire;

  logic [DW-1:0]    data_a [N_REQ];
  logic [LEN_W-1:0] len_a  [N_REQ];

  // Unpack the flat per-requester buses into indexable arrays.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign data_a[gi] = bus.req_data[gi*DW +: DW];
      assign len_a[gi]  = bus.req_len[gi*LEN_W +: LEN_W];
    end
  endgenerate

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .req_i     (bus.req),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (win_oh),
    .gnt_idx_o (win_idx),
    .any_o     (win_any)
  );

  assign in_burst = (state_q == BURST);
  // w_full is a registered FIFO flag, so this short combinational path is safe.
  assign wr_fire  = in_burst & ~bus.w_full;

  assign bus.w_en     = wr_fire;
  assign bus.w_data   = in_burst ? data_a[cur_id_q] : '0;
  assign bus.data_ack = gnt_q & {N_REQ{wr_fire}};
  assign bus.gnt      = gnt_q;
  assign bus.busy     = in_burst;
  assign bus.cur_id   = cur_id_q;

  // Pointer for the next arbitration: one past the finishing requester.
  always_comb begin
    next_ptr = ID_W'(rr_next(32'(cur_id_q), N_REQ));
`ifdef FIFO_WR_ARB_PRIO0_EN
    if (next_ptr == '0) next_ptr = ID_W'(1);
`endif
  end

  // Next-state logic: grant in IDLE, count beats down in BURST.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_id_d = cur_id_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d  = BURST;
          gnt_d    = win_oh;
          cur_id_d = win_idx;
          cnt_d    = len_a[win_idx];
        end
      end
      BURST: begin
        if (wr_fire) begin
          if (cnt_q == '0) begin
            state_d  = IDLE;
            gnt_d    = '0;
            rr_ptr_d = next_ptr;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any partial burst immediately.
  always_ff @(posedge w_clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cur_id_q <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_id_q <= cur_id_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
    end
  end

endmodule
